// File: rtl/line_buffer_v2.sv
// line_buffer_v2: programmable-depth sample delay line.
// Accepted samples are written into a circular buffer whose length equals the
// latched depth. Once depth samples have been accepted, every further accepted
// sample also emits the sample accepted depth-1 samples earlier. All channels
// share one control path and travel as one packed word.
module line_buffer_v2 #(
    parameter int DW        = 16,
    parameter int NCH       = 1,
    parameter int MAX_DEPTH = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [$clog2(MAX_DEPTH+1)-1:0] cfg_depth,
    input  logic                          in_valid,
    input  logic [NCH*DW-1:0]             data_in,
    input  logic                          flush,
    output logic [NCH*DW-1:0]             data_out,
    output logic                          out_valid,
    output logic                          primed,
    output logic                          cfg_err
);

    localparam int CW = $clog2(MAX_DEPTH+1);
    localparam int AW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
    localparam int WW = NCH * DW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic [WW-1:0] r_mem [0:MAX_DEPTH-1];

    logic [1:0]    r_state;
    logic [CW-1:0] r_depth;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_wp;

    logic          w_cfg_ok;
    logic [CW-1:0] w_wp_inc;
    logic [AW-1:0] w_wp_next;
    logic          w_wr_en;
    logic [AW-1:0] w_wr_idx;

    // Legal depth check and the wrapped next write pointer. The next write
    // location also holds the oldest stored sample, so it doubles as the read
    // index.
    always_comb begin
        w_cfg_ok  = (cfg_depth != '0) && (cfg_depth <= CW'(MAX_DEPTH));
        w_wp_inc  = CW'(r_wp) + CW'(1);
        w_wp_next = (w_wp_inc >= r_depth) ? '0 : w_wp_inc[AW-1:0];
        w_wr_en   = in_valid && !reset && !flush &&
                    ((r_state != S_IDLE) || w_cfg_ok);
        w_wr_idx  = (r_state == S_IDLE) ? '0 : r_wp;
    end

    // Sample storage; never cleared, only read after being written.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= data_in;
        end
    end

    // Control FSM, pointer/count and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_depth   <= '0;
            r_cnt     <= '0;
            r_wp      <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            primed    <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            cfg_err   <= 1'b0;
            if (flush) begin
                r_state  <= S_IDLE;
                r_cnt    <= '0;
                r_wp     <= '0;
                primed   <= 1'b0;
                data_out <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (in_valid) begin
                            if (w_cfg_ok) begin
                                r_depth <= cfg_depth;
                                r_cnt   <= CW'(1);
                                if (cfg_depth == CW'(1)) begin
                                    // Depth one: the sample is its own output.
                                    r_wp      <= '0;
                                    r_state   <= S_RUN;
                                    primed    <= 1'b1;
                                    out_valid <= 1'b1;
                                    data_out  <= data_in;
                                end else begin
                                    r_wp    <= AW'(1);
                                    r_state <= S_FILL;
                                end
                            end else begin
                                cfg_err <= 1'b1;
                            end
                        end
                    end
                    S_FILL: begin
                        if (in_valid) begin
                            r_cnt <= r_cnt + CW'(1);
                            r_wp  <= w_wp_next;
                            if (r_cnt + CW'(1) == r_depth) begin
                                r_state   <= S_RUN;
                                primed    <= 1'b1;
                                out_valid <= 1'b1;
                                data_out  <= r_mem[w_wp_next];
                            end
                        end
                    end
                    S_RUN: begin
                        if (in_valid) begin
                            r_wp      <= w_wp_next;
                            out_valid <= 1'b1;
                            // For depth one the read and write slots coincide,
                            // so the incoming sample bypasses the buffer.
                            data_out  <= (r_depth == CW'(1)) ? data_in
                                                              : r_mem[w_wp_next];
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_wp    <= '0;
                        primed  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_v2.sv
// tb_line_buffer_v2: directed stimulus with a scoreboard queue. The driver
// keeps a small reference of accepted samples and pushes every expected output
// or cfg_err pulse; an independent monitor pops and compares on each output.
module tb_line_buffer_v2;

    localparam int DW   = 16;
    localparam int NCH  = 2;
    localparam int MAXD = 32;
    localparam int CW   = $clog2(MAXD+1);
    localparam int WW   = NCH * DW;

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] cfg_depth;
    logic          in_valid;
    logic [WW-1:0] data_in;
    logic          flush;
    logic [WW-1:0] data_out;
    logic          out_valid;
    logic          primed;
    logic          cfg_err;

    line_buffer_v2 #(.DW(DW), .NCH(NCH), .MAX_DEPTH(MAXD)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_depth (cfg_depth),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .flush     (flush),
        .data_out  (data_out),
        .out_valid (out_valid),
        .primed    (primed),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_err;
        logic [WW-1:0] data;
    } exp_t;

    exp_t          sbq[$];
    int            total = 0;
    int            bad   = 0;

    logic [WW-1:0] hist[$];
    int            m_depth = 0;
    bit            m_idle  = 1'b1;
    logic [WW-1:0] m_last  = '0;

    task automatic chk(input string name, input logic [WW-1:0] act,
                       input logic [WW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every output pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1 || cfg_err === 1'b1) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got valid=%b err=%b data=%h expected nothing",
                         out_valid, cfg_err, data_out);
            end else begin
                e = sbq.pop_front();
                if (e.is_err) begin
                    if (!(cfg_err === 1'b1 && out_valid === 1'b0)) begin
                        bad++;
                        $display("FAIL sb_cfg_err: got valid=%b err=%b expected err pulse",
                                 out_valid, cfg_err);
                    end
                end else if (!(out_valid === 1'b1 && cfg_err === 1'b0 &&
                               data_out === e.data)) begin
                    bad++;
                    $display("FAIL sb_data: got valid=%b err=%b data=%h expected %h",
                             out_valid, cfg_err, data_out, e.data);
                end
            end
        end
    end

    function automatic logic [WW-1:0] pk(input int l0, input int l1);
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        a = l0[DW-1:0];
        b = l1[DW-1:0];
        return {b, a};
    endfunction

    // One clock of stimulus: update the reference, push expectations, clock,
    // then check the cycle-level outputs.
    task automatic step(input bit v, input logic [WW-1:0] d, input int cfg,
                        input bit fl, input bit rs, input string tag);
        bit            ev = 1'b0;
        bit            ee = 1'b0;
        bit            acc = 1'b0;
        logic [WW-1:0] ed;
        exp_t          e;
        ed        = m_last;
        in_valid  = v;
        data_in   = d;
        cfg_depth = cfg[CW-1:0];
        flush     = fl;
        reset     = rs;
        if (rs || fl) begin
            hist.delete();
            m_idle = 1'b1;
            if (rs) m_depth = 0;
            ed = '0;
        end else if (v) begin
            if (m_idle) begin
                if (cfg >= 1 && cfg <= MAXD) begin
                    m_depth = cfg;
                    m_idle  = 1'b0;
                    acc     = 1'b1;
                end else begin
                    ee = 1'b1;
                end
            end else begin
                acc = 1'b1;
            end
            if (acc) begin
                hist.push_back(d);
                if (hist.size() > m_depth) void'(hist.pop_front());
                if (hist.size() == m_depth) begin
                    ev = 1'b1;
                    ed = hist[0];
                end
            end
        end
        if (ev) begin
            e.is_err = 1'b0; e.data = ed; sbq.push_back(e);
        end
        if (ee) begin
            e.is_err = 1'b1; e.data = '0; sbq.push_back(e);
        end
        m_last = ed;
        @(posedge clk);
        #1;
        chk($sformatf("%s/out_valid", tag), WW'(out_valid), WW'(ev));
        chk($sformatf("%s/cfg_err", tag), WW'(cfg_err), WW'(ee));
        chk($sformatf("%s/primed", tag), WW'(primed),
            WW'(!m_idle && hist.size() == m_depth));
        chk($sformatf("%s/data_out", tag), data_out, m_last);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; data_in = '0; cfg_depth = '0;
        step(0, '0, 0, 0, 1, "reset0");
        step(0, '0, 0, 0, 1, "reset1");
        step(0, '0, 0, 0, 0, "idle");

        // Illegal depths rejected, then depth one echoes each sample.
        step(1, pk(16'h0AAA, 0), 0,  0, 0, "cfg0");
        step(1, pk(16'h0BBB, 0), 33, 0, 0, "cfg33");
        step(0, '0, 33, 0, 0, "cfg_quiet");
        step(1, pk(16'h1234, 16'h4321), 1, 0, 0, "d1_first");
        step(1, pk(16'h5678, 16'h8765), 7, 0, 0, "d1_second");
        step(0, '0, 7, 0, 0, "d1_hold");
        step(1, pk(16'h9ABC, 16'hCBA9), 0, 0, 0, "d1_third");
        step(0, '0, 0, 1, 0, "flush_a");
        step(0, '0, 0, 1, 0, "flush_idle");

        // Depth 25, continuous stream 1,2,3,...
        for (int n = 1; n <= 40; n++)
            step(1, pk(n, 0), 25, 0, 0, $sformatf("d25_k%0d", n));
        step(0, '0, 25, 1, 0, "flush_b");

        // Depth 3 with gaps between samples A..D.
        step(1, pk(16'h00A0, 16'h0A00), 3, 0, 0, "d3_A");
        step(0, '0, 3, 0, 0, "d3_gap1");
        step(1, pk(16'h00B0, 16'h0B00), 3, 0, 0, "d3_B");
        step(0, '0, 3, 0, 0, "d3_gap2");
        step(1, pk(16'h00C0, 16'h0C00), 3, 0, 0, "d3_C");
        step(0, '0, 3, 0, 0, "d3_gap3");
        step(1, pk(16'h00D0, 16'h0D00), 3, 0, 0, "d3_D");
        step(0, '0, 3, 0, 0, "d3_gap4");
        step(0, '0, 3, 1, 0, "flush_c");

        // Depth 4, two distinguishable lanes.
        for (int n = 1; n <= 12; n++)
            step(1, pk(n, 16'hFFFF - n), 4, 0, 0, $sformatf("d4_k%0d", n));
        step(0, '0, 4, 1, 0, "flush_d");

        // Depth 5: flush with a simultaneous sample, then refill.
        for (int n = 1; n <= 8; n++)
            step(1, pk(16'h0500 + n, n), 5, 0, 0, $sformatf("d5_k%0d", n));
        step(1, pk(16'hDEAD, 16'hBEEF), 5, 1, 0, "d5_flush");
        for (int n = 1; n <= 7; n++)
            step(1, pk(16'h0600 + n, 16'h60 + n), 5, 0, 0, $sformatf("d5_re%0d", n));

        // Reset mid-run together with flush and a sample, then depth 2.
        step(1, pk(16'hFACE, 16'hCAFE), 9, 1, 1, "rst_mid");
        for (int n = 1; n <= 5; n++)
            step(1, pk(16'h0700 + n, 16'h70 + n), 2, 0, 0, $sformatf("d2_k%0d", n));
        step(0, '0, 2, 0, 0, "final_idle");

        chk("sb_empty", WW'(sbq.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
